vd_tb_ctrl: RTL and testbench

- Sequencer for the Viterbi decoder back end.
- Gates ACS/survivor updates while a window of TB_DEPTH symbol pairs is accepted, then runs the traceback unit (te) over that window.
- Then drains decoded bits (oe) to a downstream consumer with backpressure.
- Repeats per window until the frame's block count is exhausted, then pulses done.

---
 rtl/vd_tb_ctrl.sv | 145 ++++++++++++++
 tb/tb_vd_tb_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vd_tb_ctrl.sv
// Viterbi back-end sequencer: gates ACS updates over a survivor window,
// runs traceback over it, then drains decoded bits under backpressure.
// This repeats once per window until the frame's block count is used up.
module vd_tb_ctrl #(
    parameter int unsigned TB_DEPTH = 8,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned BLK_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BLK_W-1:0] n_blocks,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             acs_en,
    output logic             acs_clr,
    input  logic [CNT_W-1:0] tb_cnt,
    output logic             te,
    output logic             oe,
    input  logic             dout_ready,
    output logic             dout_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(TB_DEPTH - 1);
    localparam logic [CNT_W-1:0] WdLast  = CNT_W'(2 * TB_DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StFill,
        StTrace,
        StOut,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [BLK_W-1:0] blk_rem_q, blk_rem_d;
    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             err_q, err_d;

    // State and counter registers; reset discards any latched frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            blk_rem_q <= '0;
            sym_cnt_q <= '0;
            wd_cnt_q  <= '0;
            out_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            blk_rem_q <= blk_rem_d;
            sym_cnt_q <= sym_cnt_d;
            wd_cnt_q  <= wd_cnt_d;
            out_cnt_q <= out_cnt_d;
            err_q     <= err_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d   = state_q;
        blk_rem_d = blk_rem_q;
        sym_cnt_d = sym_cnt_q;
        wd_cnt_d  = wd_cnt_q;
        out_cnt_d = out_cnt_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    err_d = 1'b0;
                    if (n_blocks != '0) begin
                        blk_rem_d = n_blocks;
                        state_d   = StInit;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StInit: begin
                sym_cnt_d = '0;
                state_d   = StFill;
            end
            StFill: begin
                if (sym_valid) begin
                    if (sym_cnt_q == LastIdx) begin
                        sym_cnt_d = '0;
                        wd_cnt_d  = '0;
                        state_d   = StTrace;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 1'b1;
                    end
                end
            end
            StTrace: begin
                wd_cnt_d = wd_cnt_q + 1'b1;
                // Completion is checked first so it beats a coincident timeout.
                if (tb_cnt == LastIdx) begin
                    out_cnt_d = '0;
                    state_d   = StOut;
                end else if (wd_cnt_q == WdLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StOut: begin
                if (dout_ready) begin
                    if (out_cnt_q == LastIdx) begin
                        out_cnt_d = '0;
                        blk_rem_d = blk_rem_q - 1'b1;
                        // Metrics carry into the next window, so no re-init.
                        state_d   = (blk_rem_q == BLK_W'(1)) ? StDone : StFill;
                    end else begin
                        out_cnt_d = out_cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore outputs decode registered state; only acs_en and oe follow inputs.
    always_comb begin
        sym_ready  = (state_q == StFill);
        acs_en     = (state_q == StFill) && sym_valid;
        acs_clr    = (state_q == StInit);
        te         = (state_q == StTrace);
        oe         = (state_q == StOut) && dout_ready;
        dout_valid = oe;
        busy       = (state_q != StIdle);
        done       = (state_q == StDone);
        err        = err_q;
    end

endmodule

// File: tb/tb_vd_tb_ctrl.sv
// Self-checking bench for vd_tb_ctrl: table of frame scenarios with
// hand-computed per-frame output counts, plus reset corner sequences.
module tb_vd_tb_ctrl;

    localparam int TB_DEPTH = 8;
    localparam int CNT_W    = 4;
    localparam int BLK_W    = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [BLK_W-1:0] n_blocks = '0;
    logic             sym_valid = 1'b0;
    logic             sym_ready;
    logic             acs_en;
    logic             acs_clr;
    logic [CNT_W-1:0] tb_cnt = '0;
    logic             te;
    logic             oe;
    logic             dout_ready = 1'b0;
    logic             dout_valid;
    logic             busy;
    logic             done;
    logic             err;

    int n_tests = 0;
    int n_fail  = 0;

    vd_tb_ctrl #(
        .TB_DEPTH(TB_DEPTH),
        .CNT_W   (CNT_W),
        .BLK_W   (BLK_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n_blocks  (n_blocks),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .acs_en    (acs_en),
        .acs_clr   (acs_clr),
        .tb_cnt    (tb_cnt),
        .te        (te),
        .oe        (oe),
        .dout_ready(dout_ready),
        .dout_valid(dout_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Frame scenario: stimulus knobs plus expected counts over the busy period.
    // tbmode: 0 = traceback counts up under te, 1 = stuck at 3,
    //         2 = stuck at 3 then reaches 7 on the watchdog's last cycle.
    typedef struct {
        int nb;
        bit vtog;
        bit rgap;
        int tbmode;
        bit noise;
        int e_clr;
        int e_en;
        int e_te;
        int e_oe;
        int e_dv;
        int e_done;
        int e_busy;
        int e_fill;
        bit e_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int  c_clr = 0, c_en = 0, c_te = 0, c_oe = 0, c_dv = 0;
        int  c_done = 0, c_busy = 0, c_fill = 0;
        int  fill_cyc = 0, out_cyc = 0, te_idx = 0;
        bit  prev_sr = 1'b0;
        bit  in_out;
        bit  fin = 1'b0;
        start      = 1'b1;
        n_blocks   = BLK_W'(v.nb);
        sym_valid  = 1'b0;
        tb_cnt     = '0;
        dout_ready = 1'b1;
        cyc();
        start    = 1'b0;
        n_blocks = '0;
        for (int k = 0; k < 1000 && !fin; k++) begin
            in_out    = busy && !sym_ready && !te && !acs_clr && !done;
            sym_valid = v.vtog ? (fill_cyc % 2 == 0) : 1'b1;
            if (te) begin
                case (v.tbmode)
                    0:       tb_cnt = CNT_W'(te_idx);
                    1:       tb_cnt = 4'd3;
                    default: tb_cnt = (te_idx == 15) ? 4'd7 : 4'd3;
                endcase
            end else begin
                tb_cnt = '0;
            end
            dout_ready = v.rgap ? (out_cyc % 3 != 2) : 1'b1;
            start      = v.noise && (sym_ready || in_out);
            #1;
            if (!busy) begin
                fin = 1'b1;
            end else begin
                c_busy++;
                if (acs_clr)    c_clr++;
                if (acs_en)     c_en++;
                if (te)         c_te++;
                if (oe)         c_oe++;
                if (dout_valid) c_dv++;
                if (done)       c_done++;
                if (sym_ready && !prev_sr) c_fill++;
                prev_sr = sym_ready;
                if (sym_ready) fill_cyc++;
                if (in_out)    out_cyc++;
                te_idx = te ? te_idx + 1 : 0;
                cyc();
            end
        end
        start      = 1'b0;
        sym_valid  = 1'b0;
        dout_ready = 1'b0;
        tb_cnt     = '0;
        check({tag, " finished"}, int'(fin), 1);
        check({tag, " acs_clr"}, c_clr, v.e_clr);
        check({tag, " acs_en"}, c_en, v.e_en);
        check({tag, " te"}, c_te, v.e_te);
        check({tag, " oe"}, c_oe, v.e_oe);
        check({tag, " dout_valid"}, c_dv, v.e_dv);
        check({tag, " done"}, c_done, v.e_done);
        check({tag, " busy"}, c_busy, v.e_busy);
        check({tag, " fill_entries"}, c_fill, v.e_fill);
        check({tag, " err"}, int'(err), int'(v.e_err));
        cyc();
        cyc();
        cyc();
        check({tag, " err_held"}, int'(err), int'(v.e_err));
        check({tag, " idle"}, int'(busy), 0);
    endtask

    initial begin
        int seen;
        //          nb vtog  rgap  tbm noise clr en  te  oe  dv  done busy fill err
        vecs[0] = '{1, 1'b0, 1'b0, 0, 1'b0, 1, 8,  8,  8,  8,  1, 26, 1, 1'b0};
        vecs[1] = '{2, 1'b1, 1'b1, 0, 1'b0, 1, 16, 16, 16, 16, 1, 72, 2, 1'b0};
        vecs[2] = '{0, 1'b0, 1'b0, 0, 1'b0, 0, 0,  0,  0,  0,  1, 1,  0, 1'b0};
        vecs[3] = '{1, 1'b0, 1'b0, 1, 1'b0, 1, 8,  16, 0,  0,  0, 25, 1, 1'b1};
        vecs[4] = '{1, 1'b0, 1'b0, 0, 1'b0, 1, 8,  8,  8,  8,  1, 26, 1, 1'b0};
        vecs[5] = '{1, 1'b0, 1'b0, 2, 1'b0, 1, 8,  16, 8,  8,  1, 34, 1, 1'b0};
        vecs[6] = '{2, 1'b0, 1'b0, 0, 1'b1, 1, 16, 16, 16, 16, 1, 50, 2, 1'b0};

        // Reset state with inputs quiet.
        #12;
        check("reset_outputs",
              int'({sym_ready, acs_en, acs_clr, te, oe, dout_valid, busy, done, err}), 0);
        #10;
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while idle clears a sticky timeout error.
        run_frame(vecs[3], "timeout_again");
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_clears_err", int'(err), 0);
        #1;
        rst_n = 1'b1;
        cyc();

        // Asynchronous reset in the middle of traceback.
        start      = 1'b1;
        n_blocks   = 8'd1;
        sym_valid  = 1'b1;
        dout_ready = 1'b1;
        tb_cnt     = '0;
        cyc();
        start = 1'b0;
        seen  = 0;
        for (int k = 0; k < 100 && seen < 3; k++) begin
            #1;
            if (te) seen++;
            if (seen < 3) cyc();
        end
        check("reach_trace", seen, 3);
        rst_n = 1'b0;
        #1;
        check("midtrace_rst_te", int'(te), 0);
        check("midtrace_rst_busy", int'(busy), 0);
        check("midtrace_rst_err", int'(err), 0);
        check("midtrace_rst_sym_ready", int'(sym_ready), 0);
        #2;
        rst_n     = 1'b1;
        sym_valid = 1'b0;
        cyc();
        run_frame(vecs[0], "after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, limit 200000");
        $fatal(1, "timeout");
    end

endmodule
